// File: rtl/unidad_atascamiento_marcador.sv
// Scoreboard-based hazard unit for the decode/execute boundary.
// Each destination register keeps a countdown of the cycles left before a
// dependent instruction in D may read it. Stalls and flushes come from those
// countdowns plus the producer currently sitting in E, so producers of any
// latency up to MAX_LAT are handled without fixed E/M/W address compares.
module unidad_atascamiento_marcador #(
    parameter int NREG    = 32,
    parameter int AW      = 5,
    parameter int MAX_LAT = 8,
    parameter int WB_DIST = 3,
    parameter int CW      = $clog2(MAX_LAT + WB_DIST),
    parameter int STW     = 32
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic [AW-1:0]                  Rs1D_i,
    input  logic [AW-1:0]                  Rs2D_i,
    input  logic                           usa_rs1_i,
    input  logic                           usa_rs2_i,
    input  logic [AW-1:0]                  RdE_i,
    input  logic                           valido_E_i,
    input  logic                           RegWriteE_i,
    input  logic [$clog2(MAX_LAT+1)-1:0]   lat_E_i,
    input  logic                           desactivar_fw_i,
    input  logic                           PCSrcE_i,
    input  logic                           bp_activo_i,
    output logic                           StallF_o,
    output logic                           StallD_o,
    output logic                           FlushD_o,
    output logic                           FlushE_o,
    output logic                           ocupado_o,
    output logic [STW-1:0]                 atascos_o
);

    localparam int LW = $clog2(MAX_LAT + 1);
    // Wide enough for the largest wait (MAX_LAT-1+WB_DIST) and the drain reload.
    localparam int WW = $clog2(MAX_LAT + WB_DIST + 1);
    localparam logic [LW-1:0] LAT_MAX       = LW'(MAX_LAT);
    localparam logic [WW-1:0] DRAIN_RECARGA = WW'(WB_DIST + MAX_LAT - 1);

    logic [CW-1:0]  r_cnt [NREG];
    logic [WW-1:0]  r_drain;
    logic           r_modo;
    logic [STW-1:0] r_atascos;

    logic [LW-1:0]  w_lat;
    logic [WW-1:0]  w_wait;
    logic [CW-1:0]  w_pend;
    logic           w_iss;
    logic           w_haz_rs1;
    logic           w_haz_rs2;
    logic           w_haz;
    logic           w_mis;
    logic           w_stall;
    logic           w_ocupado;
    logic [CW-1:0]  w_cnt_dec [NREG];

    // Effective latency and the wait a dependent in D must see; lat 0 counts as 1.
    always_comb begin
        w_lat = lat_E_i;
        if (lat_E_i == '0) begin
            w_lat = LW'(1);
        end else if (lat_E_i > LAT_MAX) begin
            w_lat = LAT_MAX;
        end
        w_wait = WW'(w_lat) - WW'(1) + (desactivar_fw_i ? WW'(WB_DIST) : WW'(0));
        w_pend = (w_wait != '0) ? CW'(w_wait - WW'(1)) : '0;
        w_iss  = valido_E_i & RegWriteE_i & (RdE_i != '0);
    end

    // Per-source hazard: the producer in E (combinational) or a pending countdown.
    always_comb begin
        w_haz_rs1 = 1'b0;
        w_haz_rs2 = 1'b0;
        if (usa_rs1_i && (Rs1D_i != '0)) begin
            w_haz_rs1 = (w_iss && (RdE_i == Rs1D_i) && (w_wait != '0)) ||
                        (r_cnt[Rs1D_i] != '0);
        end
        if (usa_rs2_i && (Rs2D_i != '0)) begin
            w_haz_rs2 = (w_iss && (RdE_i == Rs2D_i) && (w_wait != '0)) ||
                        (r_cnt[Rs2D_i] != '0);
        end
        w_haz   = w_haz_rs1 | w_haz_rs2 | (r_drain != '0);
        w_mis   = PCSrcE_i & ~bp_activo_i;
        w_stall = w_haz & ~w_mis;
    end

    // Countdowns after this edge's decrement, before a new issue is merged in.
    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            w_cnt_dec[i] = (r_cnt[i] != '0) ? (r_cnt[i] - CW'(1)) : '0;
        end
    end

    // Busy whenever any register is still pending or a mode drain is running.
    always_comb begin
        w_ocupado = (r_drain != '0);
        for (int i = 0; i < NREG; i++) begin
            if (r_cnt[i] != '0) begin
                w_ocupado = 1'b1;
            end
        end
    end

    // Scoreboard update: an issue never shortens an older, longer pending write.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NREG; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_cnt[0] <= '0;
            for (int i = 1; i < NREG; i++) begin
                if (w_iss && (RdE_i == AW'(i)) && (w_pend > w_cnt_dec[i])) begin
                    r_cnt[i] <= w_pend;
                end else begin
                    r_cnt[i] <= w_cnt_dec[i];
                end
            end
        end
    end

    // Forwarding-mode tracking; any change restarts a full drain window.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_modo  <= desactivar_fw_i;
            r_drain <= '0;
        end else begin
            r_modo <= desactivar_fw_i;
            if (desactivar_fw_i != r_modo) begin
                r_drain <= DRAIN_RECARGA;
            end else if (r_drain != '0) begin
                r_drain <= r_drain - WW'(1);
            end
        end
    end

    // Saturating count of cycles in which decode was held.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_atascos <= '0;
        end else if (w_stall && (r_atascos != '1)) begin
            r_atascos <= r_atascos + STW'(1);
        end
    end

    assign StallF_o  = w_stall;
    assign StallD_o  = w_stall;
    assign FlushD_o  = w_mis;
    assign FlushE_o  = w_haz | w_mis;
    assign ocupado_o = w_ocupado;
    assign atascos_o = r_atascos;

endmodule

// File: tb/tb_unidad_atascamiento_marcador.sv
// Self-checking bench for the scoreboard hazard unit. The reference model
// tracks, per register, the absolute cycle at which its value becomes
// readable, and the absolute cycle at which a mode drain ends.
module tb_unidad_atascamiento_marcador;

    localparam int NREG    = 32;
    localparam int AW      = 5;
    localparam int MAX_LAT = 8;
    localparam int WB_DIST = 3;
    localparam int STW     = 32;
    localparam int LW      = $clog2(MAX_LAT + 1);

    logic            clk_i = 1'b0;
    logic            rst_i = 1'b1;
    logic [AW-1:0]   Rs1D_i = '0;
    logic [AW-1:0]   Rs2D_i = '0;
    logic            usa_rs1_i = 1'b0;
    logic            usa_rs2_i = 1'b0;
    logic [AW-1:0]   RdE_i = '0;
    logic            valido_E_i = 1'b0;
    logic            RegWriteE_i = 1'b0;
    logic [LW-1:0]   lat_E_i = '0;
    logic            desactivar_fw_i = 1'b0;
    logic            PCSrcE_i = 1'b0;
    logic            bp_activo_i = 1'b0;
    logic            StallF_o, StallD_o, FlushD_o, FlushE_o, ocupado_o;
    logic [STW-1:0]  atascos_o;

    wire [4:0] obsVec = {StallF_o, StallD_o, FlushD_o, FlushE_o, ocupado_o};

    int checksTotal  = 0;
    int checksPassed = 0;

    // Reference model state
    int      ciclo = 0;
    int      listo [NREG];
    int      drainHasta = 0;
    bit      modoModelo = 1'b0;
    longint  atascosModelo = 0;
    logic [4:0]     expVec;
    logic [STW-1:0] expAtascos;
    bit      expStall;
    bit      ultIss;
    int      ultRd;
    int      ultW;

    unidad_atascamiento_marcador dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .Rs1D_i(Rs1D_i), .Rs2D_i(Rs2D_i),
        .usa_rs1_i(usa_rs1_i), .usa_rs2_i(usa_rs2_i),
        .RdE_i(RdE_i), .valido_E_i(valido_E_i), .RegWriteE_i(RegWriteE_i),
        .lat_E_i(lat_E_i), .desactivar_fw_i(desactivar_fw_i),
        .PCSrcE_i(PCSrcE_i), .bp_activo_i(bp_activo_i),
        .StallF_o(StallF_o), .StallD_o(StallD_o),
        .FlushD_o(FlushD_o), .FlushE_o(FlushE_o),
        .ocupado_o(ocupado_o), .atascos_o(atascos_o)
    );

    always #5 clk_i = ~clk_i;

    // Expected outputs for the current cycle from the readiness model.
    function automatic void calcular();
        int  l, w, r1, r2;
        bit  iss, h1, h2, dr, mis, oc;
        l = int'(lat_E_i);
        if (l < 1) l = 1;
        if (l > MAX_LAT) l = MAX_LAT;
        w = l - 1 + (desactivar_fw_i ? WB_DIST : 0);
        iss = valido_E_i && RegWriteE_i && (RdE_i != 0);
        r1 = listo[Rs1D_i];
        if (iss && RdE_i == Rs1D_i && ciclo + w > r1) r1 = ciclo + w;
        r2 = listo[Rs2D_i];
        if (iss && RdE_i == Rs2D_i && ciclo + w > r2) r2 = ciclo + w;
        h1  = usa_rs1_i && (Rs1D_i != 0) && (r1 > ciclo);
        h2  = usa_rs2_i && (Rs2D_i != 0) && (r2 > ciclo);
        dr  = ciclo < drainHasta;
        oc  = dr;
        for (int r = 1; r < NREG; r++) if (listo[r] > ciclo) oc = 1'b1;
        mis = PCSrcE_i && !bp_activo_i;
        expStall   = (h1 || h2 || dr) && !mis;
        expVec     = {expStall, expStall, mis, (h1 || h2 || dr || mis), oc};
        expAtascos = atascosModelo[STW-1:0];
        ultIss = iss;
        ultRd  = int'(RdE_i);
        ultW   = w;
    endfunction

    task automatic muestra();
        @(negedge clk_i);
        calcular();
    endtask

    // Clock edge plus the matching model update.
    task automatic avanzar();
        @(posedge clk_i);
        if (rst_i) begin
            for (int r = 0; r < NREG; r++) listo[r] = 0;
            drainHasta    = 0;
            modoModelo    = desactivar_fw_i;
            atascosModelo = 0;
        end else begin
            if (expStall && atascosModelo < ((64'd1 << STW) - 1)) atascosModelo++;
            if (ultIss && ciclo + ultW > listo[ultRd]) listo[ultRd] = ciclo + ultW;
            if (desactivar_fw_i != modoModelo) begin
                drainHasta = ciclo + 1 + WB_DIST + MAX_LAT - 1;
                modoModelo = desactivar_fw_i;
            end
        end
        ciclo++;
        #1;
    endtask

    task automatic applyStimulus(input int rs1, input int rs2, input bit u1, input bit u2,
                                 input int rd, input bit val, input bit rw, input int lat,
                                 input bit pcsrc, input bit bp);
        Rs1D_i = AW'(rs1);  Rs2D_i = AW'(rs2);
        usa_rs1_i = u1;     usa_rs2_i = u2;
        RdE_i = AW'(rd);    valido_E_i = val;  RegWriteE_i = rw;
        lat_E_i = LW'(lat); PCSrcE_i = pcsrc;  bp_activo_i = bp;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        desactivar_fw_i = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk_i); #1;
        muestra(); avanzar();
        rst_i = 1'b0;
        muestra();
        checksTotal++;
        if (obsVec !== 5'b0) $display("[TB] FAIL reset_outs got %b want %b", obsVec, 5'b0);
        else checksPassed++;
        checksTotal++;
        if (atascos_o !== '0) $display("[TB] FAIL reset_atascos got %0d want 0", atascos_o);
        else checksPassed++;
        avanzar();
    endtask

    task automatic test_load_fw();
        int stalls = 0;
        applyStimulus(5, 0, 1, 0, 5, 1, 1, 2, 0, 0);
        for (int c = 0; c < 4; c++) begin
            muestra();
            checksTotal++;
            if (obsVec !== expVec) $display("[TB] FAIL load_fw c%0d got %b want %b", c, obsVec, expVec);
            else checksPassed++;
            if (StallD_o) stalls++;
            avanzar();
            applyStimulus(5, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        end
        checksTotal++;
        if (stalls != 1) $display("[TB] FAIL load_fw_len got %0d want 1", stalls);
        else checksPassed++;
        checksTotal++;
        if (atascos_o !== STW'(1)) $display("[TB] FAIL load_fw_atascos got %0d want 1", atascos_o);
        else checksPassed++;
    endtask

    task automatic test_x0_usa();
        int stalls = 0;
        for (int c = 0; c < 6; c++) begin
            if (c == 0) applyStimulus(0, 0, 1, 1, 0, 1, 1, 4, 0, 0);
            else if (c == 1) applyStimulus(6, 6, 0, 0, 6, 1, 1, 4, 0, 0);
            else applyStimulus(6, 0, 0, 0, 0, 0, 0, 0, 0, 0);
            muestra();
            checksTotal++;
            if (obsVec !== expVec) $display("[TB] FAIL x0_usa c%0d got %b want %b", c, obsVec, expVec);
            else checksPassed++;
            if (StallD_o) stalls++;
            avanzar();
        end
        checksTotal++;
        if (stalls != 0) $display("[TB] FAIL x0_usa_len got %0d want 0", stalls);
        else checksPassed++;
    endtask

    task automatic test_mul_then_alu();
        int stalls = 0;
        for (int c = 0; c < 9; c++) begin
            if (c == 0) applyStimulus(0, 0, 0, 0, 9, 1, 1, 6, 0, 0);
            else if (c == 1) applyStimulus(0, 0, 0, 0, 9, 1, 1, 1, 0, 0);
            else applyStimulus(9, 0, 1, 0, 0, 0, 0, 0, 0, 0);
            muestra();
            checksTotal++;
            if (obsVec !== expVec) $display("[TB] FAIL mul_alu c%0d got %b want %b", c, obsVec, expVec);
            else checksPassed++;
            if (StallD_o) stalls++;
            avanzar();
        end
        checksTotal++;
        if (stalls != 3) $display("[TB] FAIL mul_alu_len got %0d want 3", stalls);
        else checksPassed++;
    endtask

    task automatic test_mispredict();
        applyStimulus(5, 0, 1, 0, 5, 1, 1, 3, 1, 0);
        muestra();
        checksTotal++;
        if (obsVec !== expVec) $display("[TB] FAIL mis_model got %b want %b", obsVec, expVec);
        else checksPassed++;
        checksTotal++;
        if ({StallD_o, FlushD_o, FlushE_o} !== 3'b011)
            $display("[TB] FAIL mis_redirect got %b want 011", {StallD_o, FlushD_o, FlushE_o});
        else checksPassed++;
        avanzar();
        applyStimulus(5, 0, 1, 0, 0, 0, 0, 0, 1, 1);
        muestra();
        checksTotal++;
        if ({StallD_o, FlushD_o, FlushE_o} !== 3'b101)
            $display("[TB] FAIL mis_predicted got %b want 101", {StallD_o, FlushD_o, FlushE_o});
        else checksPassed++;
        avanzar();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int c = 0; c < 3; c++) begin
            muestra();
            checksTotal++;
            if (obsVec !== expVec) $display("[TB] FAIL mis_tail c%0d got %b want %b", c, obsVec, expVec);
            else checksPassed++;
            avanzar();
        end
    endtask

    task automatic test_mode_switch();
        int stalls = 0;
        int busy = 0;
        desactivar_fw_i = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int c = 0; c < 14; c++) begin
            muestra();
            checksTotal++;
            if (obsVec !== expVec) $display("[TB] FAIL mode_sw c%0d got %b want %b", c, obsVec, expVec);
            else checksPassed++;
            if (StallD_o) stalls++;
            if (StallD_o && ocupado_o) busy++;
            avanzar();
        end
        checksTotal++;
        if (stalls != WB_DIST + MAX_LAT - 1 || busy != stalls)
            $display("[TB] FAIL mode_sw_len got %0d/%0d want %0d", stalls, busy, WB_DIST + MAX_LAT - 1);
        else checksPassed++;
    endtask

    task automatic test_alu_nofw();
        int stalls = 0;
        applyStimulus(0, 7, 0, 1, 7, 1, 1, 1, 0, 0);
        for (int c = 0; c < 6; c++) begin
            muestra();
            checksTotal++;
            if (obsVec !== expVec) $display("[TB] FAIL alu_nofw c%0d got %b want %b", c, obsVec, expVec);
            else checksPassed++;
            if (StallD_o) stalls++;
            avanzar();
            applyStimulus(0, 7, 0, 1, 0, 0, 0, 0, 0, 0);
        end
        checksTotal++;
        if (stalls != 3) $display("[TB] FAIL alu_nofw_len got %0d want 3", stalls);
        else checksPassed++;
    endtask

    task automatic test_reset_mid_drain();
        desactivar_fw_i = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int c = 0; c < 4; c++) begin
            muestra();
            checksTotal++;
            if (obsVec !== expVec) $display("[TB] FAIL drain_pre c%0d got %b want %b", c, obsVec, expVec);
            else checksPassed++;
            avanzar();
        end
        rst_i = 1'b1;
        muestra(); avanzar();
        rst_i = 1'b0;
        muestra();
        checksTotal++;
        if (obsVec !== 5'b0 || atascos_o !== '0)
            $display("[TB] FAIL drain_rst got %b/%0d want 00000/0", obsVec, atascos_o);
        else checksPassed++;
        avanzar();
    endtask

    task automatic test_random();
        for (int c = 0; c < 500; c++) begin
            applyStimulus($urandom_range(0, 7), $urandom_range(0, 7),
                          1'($urandom), 1'($urandom), $urandom_range(0, 7),
                          ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0),
                          $urandom_range(0, 15), ($urandom_range(0, 7) == 0), 1'($urandom));
            if ($urandom_range(0, 39) == 0) desactivar_fw_i = ~desactivar_fw_i;
            rst_i = ($urandom_range(0, 99) == 0);
            muestra();
            checksTotal++;
            if (obsVec !== expVec) $display("[TB] FAIL rand c%0d got %b want %b", c, obsVec, expVec);
            else checksPassed++;
            checksTotal++;
            if (atascos_o !== expAtascos) $display("[TB] FAIL rand_atascos c%0d got %0d want %0d", c, atascos_o, expAtascos);
            else checksPassed++;
            avanzar();
        end
        rst_i = 1'b0;
    endtask

    initial begin
        for (int r = 0; r < NREG; r++) listo[r] = 0;
        test_reset();
        test_load_fw();
        test_x0_usa();
        test_mul_then_alu();
        test_mispredict();
        test_mode_switch();
        test_alu_nofw();
        test_reset_mid_drain();
        test_random();
        $display("%0d/%0d checks passed", checksPassed, checksTotal);
        $finish;
    end

endmodule
